store_set_id_table: RTL and testbench

//  Store Set ID Table (SSIT) of the store-set memory dependence predictor. It is indexed by
//  PC bits and returns a store set ID for each of the two decoded instructions.
//  The IDs feed last_fetch_store_table directly in the same cycle.
//  On each load/store ordering violation it creates or merges store sets.
//  A cyclic sweep periodically clears every entry so that stale dependences age out.

---
 rtl/store_set_id_table.sv | 170 +++++++++++++++++
 tb/tb_store_set_id_table.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/store_set_id_table.sv
// Store Set ID Table: two-slot PC-indexed lookup of store set IDs, violation-driven
// set creation/merging, and a periodic full-table sweep that ages out dependences.
module store_set_id_table #(
    parameter int unsigned SSIT_WIDTH     = 10,
    parameter int unsigned LFST_WIDTH     = 7,
    parameter int unsigned CLEAR_INTERVAL = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SSIT_WIDTH-1:0] instr0_pc,
    input  logic [SSIT_WIDTH-1:0] instr1_pc,
    output logic [LFST_WIDTH-1:0] instr0_store_set_id,
    output logic [LFST_WIDTH-1:0] instr1_store_set_id,
    input  logic                  viol_valid,
    input  logic [SSIT_WIDTH-1:0] viol_load_pc,
    input  logic [SSIT_WIDTH-1:0] viol_store_pc,
    output logic                  clear_busy,
    output logic                  alloc_exhausted
);

    localparam int unsigned SSIT_SIZE = 1 << SSIT_WIDTH;
    localparam int unsigned LFST_SIZE = 1 << LFST_WIDTH;
    localparam int unsigned CNT_W     = $clog2(CLEAR_INTERVAL);

    localparam logic [LFST_WIDTH-1:0] ID_NONE     = '0;
    localparam logic [LFST_WIDTH-1:0] ID_SERIAL   = LFST_WIDTH'(1);
    localparam logic [LFST_WIDTH-1:0] ID_FIRST    = LFST_WIDTH'(2);
    localparam logic [LFST_WIDTH-1:0] ID_LAST     = LFST_WIDTH'(LFST_SIZE - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(CLEAR_INTERVAL - 1);
    localparam logic [SSIT_WIDTH-1:0] SWEEP_LAST  = SSIT_WIDTH'(SSIT_SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [LFST_WIDTH-1:0] ssit_q [SSIT_SIZE];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SSIT_WIDTH-1:0] sweep_q, sweep_d;
    logic [LFST_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
    logic                  exhausted_d;
    logic                  clr_we;

    logic [LFST_WIDTH-1:0] ld_id, st_id, new_id, min_id;
    logic [LFST_WIDTH-1:0] wr_ld_id, wr_st_id;
    logic                  wr_ld, wr_st, take_new;

    assign instr0_store_set_id = ssit_q[instr0_pc];
    assign instr1_store_set_id = ssit_q[instr1_pc];

    // Violation resolution: create, copy into the empty side, or merge to the smaller ID.
    always_comb begin
        ld_id    = ssit_q[viol_load_pc];
        st_id    = ssit_q[viol_store_pc];
        new_id   = alloc_exhausted ? ID_SERIAL : alloc_ptr_q;
        min_id   = (ld_id < st_id) ? ld_id : st_id;
        wr_ld    = 1'b0;
        wr_st    = 1'b0;
        wr_ld_id = ID_NONE;
        wr_st_id = ID_NONE;
        take_new = 1'b0;
        if (viol_valid) begin
            if (viol_load_pc == viol_store_pc) begin
                if (ld_id == ID_NONE) begin
                    wr_ld    = 1'b1;
                    wr_ld_id = new_id;
                    take_new = 1'b1;
                end
            end else if (ld_id == ID_NONE && st_id == ID_NONE) begin
                wr_ld    = 1'b1;
                wr_st    = 1'b1;
                wr_ld_id = new_id;
                wr_st_id = new_id;
                take_new = 1'b1;
            end else if (ld_id == ID_NONE) begin
                wr_ld    = 1'b1;
                wr_ld_id = st_id;
            end else if (st_id == ID_NONE) begin
                wr_st    = 1'b1;
                wr_st_id = ld_id;
            end else if (ld_id != st_id) begin
                wr_ld    = 1'b1;
                wr_st    = 1'b1;
                wr_ld_id = min_id;
                wr_st_id = min_id;
            end
        end
    end

    // Sweep FSM next state plus ID allocator; end of sweep restarts allocation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_d     = sweep_q;
        alloc_ptr_d = alloc_ptr_q;
        exhausted_d = alloc_exhausted;
        clr_we      = 1'b0;

        if (take_new && !alloc_exhausted) begin
            if (alloc_ptr_q == ID_LAST) begin
                exhausted_d = 1'b1;
            end else begin
                alloc_ptr_d = alloc_ptr_q + LFST_WIDTH'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                sweep_d = sweep_q + SSIT_WIDTH'(1);
                if (sweep_q == SWEEP_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    alloc_ptr_d = ID_FIRST;
                    exhausted_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            sweep_q         <= '0;
            alloc_ptr_q     <= ID_FIRST;
            alloc_exhausted <= 1'b0;
            clear_busy      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sweep_q         <= sweep_d;
            alloc_ptr_q     <= alloc_ptr_d;
            alloc_exhausted <= exhausted_d;
            clear_busy      <= (state_d == CLEAR);
        end
    end

    // Table storage; violation writes are ordered after the sweep clear so they win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SSIT_SIZE; i++) begin
                ssit_q[i] <= ID_NONE;
            end
        end else begin
            if (clr_we) begin
                ssit_q[sweep_q] <= ID_NONE;
            end
            if (wr_ld) begin
                ssit_q[viol_load_pc] <= wr_ld_id;
            end
            if (wr_st) begin
                ssit_q[viol_store_pc] <= wr_st_id;
            end
        end
    end

endmodule

// File: tb/tb_store_set_id_table.sv
// Bench for store_set_id_table: directed violations and sweeps; expectations are queued
// by the stimulus and compared by a negedge monitor.
module tb_store_set_id_table;

    localparam int unsigned SW = 10;
    localparam int unsigned LW = 4;

    logic          clk;
    logic          rst;
    logic [SW-1:0] instr0_pc, instr1_pc;
    logic          viol_valid;
    logic [SW-1:0] viol_load_pc, viol_store_pc;

    logic [LW-1:0] a_id0, a_id1, b_id0, b_id1;
    logic          a_busy, a_exh, b_busy, b_exh;

    typedef struct {
        bit          sel;
        string       name;
        int          id0;
        int          id1;
        int          busy;
        int          exh;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    store_set_id_table #(.SSIT_WIDTH(SW), .LFST_WIDTH(LW), .CLEAR_INTERVAL(4096)) dut (
        .clk(clk), .rst(rst),
        .instr0_pc(instr0_pc), .instr1_pc(instr1_pc),
        .instr0_store_set_id(a_id0), .instr1_store_set_id(a_id1),
        .viol_valid(viol_valid), .viol_load_pc(viol_load_pc), .viol_store_pc(viol_store_pc),
        .clear_busy(a_busy), .alloc_exhausted(a_exh)
    );

    store_set_id_table #(.SSIT_WIDTH(SW), .LFST_WIDTH(LW), .CLEAR_INTERVAL(16)) dut16 (
        .clk(clk), .rst(rst),
        .instr0_pc(instr0_pc), .instr1_pc(instr1_pc),
        .instr0_store_set_id(b_id0), .instr1_store_set_id(b_id1),
        .viol_valid(viol_valid), .viol_load_pc(viol_load_pc), .viol_store_pc(viol_store_pc),
        .clear_busy(b_busy), .alloc_exhausted(b_exh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, got, want);
        end
    endtask

    // Monitor: compare every queued expectation against the selected instance.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "id0",  int'(e.sel ? b_id0  : a_id0),  e.id0);
            cmp(e.name, "id1",  int'(e.sel ? b_id1  : a_id1),  e.id1);
            cmp(e.name, "busy", int'(e.sel ? b_busy : a_busy), e.busy);
            cmp(e.name, "exh",  int'(e.sel ? b_exh  : a_exh),  e.exh);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input bit sel, input string name, input int p0, input int p1,
                       input int e0, input int e1, input int busy, input int exh);
        exp_t e;
        instr0_pc = SW'(p0);
        instr1_pc = SW'(p1);
        e.sel = sel; e.name = name; e.id0 = e0; e.id1 = e1; e.busy = busy; e.exh = exh;
        exp_q.push_back(e);
        tick(1);
    endtask

    task automatic viol(input int l, input int s);
        viol_valid    = 1'b1;
        viol_load_pc  = SW'(l);
        viol_store_pc = SW'(s);
        tick(1);
        viol_valid    = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; viol_valid = 1'b0; viol_load_pc = '0; viol_store_pc = '0;
        instr0_pc = '0; instr1_pc = '0;
        reset_pulse();

        chk(0, "reset", 'h10, 'h3FF, 0, 0, 0, 0);

        viol_valid = 1'b1; viol_load_pc = SW'('h20); viol_store_pc = SW'('h40);
        chk(0, "no_bypass", 'h20, 'h40, 0, 0, 0, 0);
        viol_valid = 1'b0;
        chk(0, "new_set", 'h20, 'h40, 2, 2, 0, 0);
        viol('h21, 'h41);
        chk(0, "new_set2", 'h21, 'h41, 3, 3, 0, 0);

        viol('h60, 'h61);
        viol('h62, 'h63);
        viol('h70, 'h62);
        viol('h71, 'h21);
        chk(0, "copy_to_load", 'h70, 'h71, 5, 3, 0, 0);
        viol('h70, 'h71);
        chk(0, "merge_min", 'h70, 'h71, 3, 3, 0, 0);
        chk(0, "merge_others", 'h62, 'h21, 5, 3, 0, 0);
        viol('h50, 'h71);
        chk(0, "copy_store_id", 'h50, 'h71, 3, 3, 0, 0);
        viol('h50, 'h90);
        chk(0, "copy_to_store", 'h90, 'h50, 3, 3, 0, 0);
        viol('h70, 'h71);
        chk(0, "equal_nowrite", 'h70, 'h71, 3, 3, 0, 0);
        viol('h60, 'h62);
        chk(0, "merge_ld_min", 'h60, 'h62, 4, 4, 0, 0);
        viol('h80, 'h80);
        chk(0, "alias_new", 'h80, 'h81, 6, 0, 0, 0);
        viol('h80, 'h80);
        viol('h82, 'h83);
        chk(0, "alias_one_id", 'h82, 'h83, 7, 7, 0, 0);

        for (int k = 8; k <= 15; k++) begin
            viol('h100 + 2 * (k - 8), 'h101 + 2 * (k - 8));
            chk(0, "alloc_run", 'h100 + 2 * (k - 8), 'h101 + 2 * (k - 8), k, k, 0, (k == 15) ? 1 : 0);
        end
        viol('h200, 'h201);
        chk(0, "exhausted_serial", 'h200, 'h201, 1, 1, 0, 1);

        begin
            int n = 0;
            while (!a_busy && n < 6000) begin tick(1); n++; end
            checks++;
            if (!a_busy) begin errors++; $display("FAIL sweep_start: got busy 0 expected 1 within 6000 cycles"); end
            n = 0;
            while (a_busy && n < 2000) begin tick(1); n++; end
            checks++;
            if (a_busy) begin errors++; $display("FAIL sweep_end: got busy 1 expected 0 within 2000 cycles"); end
        end
        chk(0, "after_sweep", 'h20, 'h200, 0, 0, 0, 0);
        viol('h300, 'h301);
        chk(0, "alloc_restart", 'h300, 'h301, 2, 2, 0, 0);

        reset_pulse();
        viol('h01, 'h02);
        viol('h03, 'h04);
        viol('h05, 'h06);
        chk(1, "t5_setup", 'h05, 'h06, 4, 4, 0, 0);
        tick(11);
        chk(1, "t5_pre_sweep", 'h05, 'h06, 4, 4, 0, 0);
        chk(1, "t5_sweep_rise", 'h05, 'h06, 4, 4, 1, 0);
        tick(15);
        viol_valid = 1'b1; viol_load_pc = SW'('h10); viol_store_pc = SW'('h11);
        chk(1, "t5_collide_pre", 'h10, 'h11, 0, 0, 1, 0);
        viol_valid = 1'b0;
        chk(1, "t5_viol_wins", 'h10, 'h11, 5, 5, 1, 0);
        chk(1, "t5_swept_after", 'h10, 'h11, 5, 0, 1, 0);
        chk(1, "t5_swept", 'h05, 'h06, 0, 0, 1, 0);
        tick(1003);
        chk(1, "t5_last_busy", 'h3FF, 'h10, 0, 5, 1, 0);
        chk(1, "t5_sweep_done", 'h05, 'h10, 0, 5, 0, 0);
        viol('h3F0, 'h3F1);
        chk(1, "t6_populate", 'h3F0, 'h3F1, 2, 2, 0, 0);
        tick(13);
        chk(1, "t6_mid_sweep", 'h3F0, 'h10, 2, 5, 1, 0);
        tick(5);
        rst = 1'b1;
        chk(1, "t6_async_rst", 'h3F0, 'h10, 0, 0, 0, 0);
        rst = 1'b0;
        chk(1, "t6_after_rst", 'h3F0, 'h3F1, 0, 0, 0, 0);
        tick(14);
        chk(1, "t6_cnt_restart", 'h3F0, 'h3F1, 0, 0, 0, 0);
        chk(1, "t6_sweep_rise", 'h3F0, 'h3F1, 0, 0, 1, 0);

        tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
